// File: rtl/inv_subbytes_collector.sv
// Packs a stream of inverse S-box result bytes, MSB byte first, into NBYTES-wide
// state words. The accumulator is double-buffered against the output register.
module inv_subbytes_collector #(
    parameter int NBYTES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [8*NBYTES-1:0]   out_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            fill_count
);

    localparam int          W    = 8 * NBYTES;
    localparam int          IW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [4:0]  LAST = 5'(NBYTES - 1);

    logic [4:0]    fill_q, fill_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  state_q, state_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] idx_s;
    logic [W-1:0]  full_s;
    logic          accept_s;
    logic          last_s;

    // Back-pressure only when the final byte would overwrite an untaken word.
    always_comb begin
        if (flush) begin
            in_ready = 1'b0;
        end else if ((fill_q == LAST) && valid_q && !out_ready) begin
            in_ready = 1'b0;
        end else begin
            in_ready = 1'b1;
        end
    end

    // Byte lane for the current fill position and the word it would complete.
    always_comb begin
        idx_s            = IW'(W - 8 - 8 * int'(fill_q));
        full_s           = acc_q;
        full_s[idx_s +: 8] = in_byte;
        accept_s         = in_valid && in_ready;
        last_s           = accept_s && (fill_q == LAST);
    end

    // Next-state for the accumulator and the output buffer.
    always_comb begin
        fill_d  = fill_q;
        acc_d   = acc_q;
        state_d = state_q;
        valid_d = valid_q;
        if (flush) begin
            fill_d = 5'd0;
            acc_d  = {W{1'b0}};
        end else if (last_s) begin
            fill_d  = 5'd0;
            acc_d   = {W{1'b0}};
            state_d = full_s;
        end else if (accept_s) begin
            fill_d = fill_q + 5'd1;
            acc_d  = full_s;
        end else begin
            fill_d = fill_q;
        end
        if (last_s) begin
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q  <= 5'd0;
            acc_q   <= {W{1'b0}};
            state_q <= {W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            fill_q  <= fill_d;
            acc_q   <= acc_d;
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    assign out_state  = state_q;
    assign out_valid  = valid_q;
    assign fill_count = fill_q;

endmodule

// File: tb/tb_inv_subbytes_collector.sv
// Directed and randomized checks of inv_subbytes_collector at NBYTES = 16, 4 and 1,
// against a byte-queue reference model.
module tb_inv_subbytes_collector;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_byte_s  [3];
    logic         in_valid_s [3];
    logic         flush_s    [3];
    logic         out_ready_s[3];
    logic         in_ready_s [3];
    logic         out_valid_s[3];
    logic [4:0]   fill_s     [3];
    logic [127:0] os16;
    logic [31:0]  os4;
    logic [7:0]   os1;

    always #5 clk = ~clk;

    inv_subbytes_collector #(.NBYTES(16)) u16 (
        .clk(clk), .rst(rst), .in_byte(in_byte_s[0]), .in_valid(in_valid_s[0]),
        .in_ready(in_ready_s[0]), .flush(flush_s[0]), .out_state(os16),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .fill_count(fill_s[0]));
    inv_subbytes_collector #(.NBYTES(4)) u4 (
        .clk(clk), .rst(rst), .in_byte(in_byte_s[1]), .in_valid(in_valid_s[1]),
        .in_ready(in_ready_s[1]), .flush(flush_s[1]), .out_state(os4),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .fill_count(fill_s[1]));
    inv_subbytes_collector #(.NBYTES(1)) u1 (
        .clk(clk), .rst(rst), .in_byte(in_byte_s[2]), .in_valid(in_valid_s[2]),
        .in_ready(in_ready_s[2]), .flush(flush_s[2]), .out_state(os1),
        .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .fill_count(fill_s[2]));

    int           cur = 0;
    int           nb  = 16;
    int           n_cmp = 0;
    int           n_mis = 0;
    int           words_out = 0;
    logic [7:0]   part[$];
    bit           pend = 1'b0;
    logic [127:0] pend_word = '0;
    logic [127:0] obs_state;
    logic         obs_rdy, obs_valid;
    logic [4:0]   obs_fill;

    always_comb begin
        obs_rdy   = in_ready_s[cur];
        obs_valid = out_valid_s[cur];
        obs_fill  = fill_s[cur];
        case (cur)
            0:       obs_state = os16;
            1:       obs_state = {96'd0, os4};
            default: obs_state = {120'd0, os1};
        endcase
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_part();
        logic [127:0] w = '0;
        foreach (part[i]) w = {w[119:0], part[i]};
        return w;
    endfunction

    task automatic model_reset(input int idx, input int n);
        cur = idx; nb = n;
        part.delete(); pend = 1'b0; pend_word = '0;
        for (int i = 0; i < 3; i++) begin
            in_byte_s[i] = 8'h00; in_valid_s[i] = 1'b0;
            flush_s[i] = 1'b0; out_ready_s[i] = 1'b0;
        end
    endtask

    // One clock: drive at posedge+1, check at negedge, update the model at posedge.
    task automatic cycle(input logic v, input logic [7:0] b, input logic ordy, input logic fl);
        logic exp_rdy;
        in_byte_s[cur] = b; in_valid_s[cur] = v; out_ready_s[cur] = ordy; flush_s[cur] = fl;
        exp_rdy = !fl && !((part.size() == nb - 1) && pend && !ordy);
        @(negedge clk);
        chk("in_ready", {127'd0, obs_rdy}, {127'd0, exp_rdy});
        chk("out_valid", {127'd0, obs_valid}, {127'd0, pend});
        chk("fill_count", {123'd0, obs_fill}, 128'(part.size()));
        if (pend) chk("out_state", obs_state, pend_word);
        @(posedge clk);
        if (pend && ordy) begin
            pend = 1'b0;
            words_out++;
        end
        if (fl) begin
            part.delete();
        end else if (v && exp_rdy) begin
            part.push_back(b);
            if (part.size() == nb) begin
                pend_word = pack_part();
                pend = 1'b1;
                part.delete();
            end
        end
        #1;
    endtask

    initial begin
        logic [127:0] w1;
        model_reset(0, 16);
        #2;
        chk("reset_out_valid", {127'd0, obs_valid}, 128'd0);
        chk("reset_out_state", obs_state, 128'd0);
        chk("reset_fill", {123'd0, obs_fill}, 128'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Sixteen back-to-back bytes 0x00..0x0F.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
        chk("seq_valid", {127'd0, obs_valid}, 128'd1);
        chk("seq_word", obs_state, 128'h000102030405060708090A0B0C0D0E0F);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Word pending with consumer stalled, next word collects up to the last byte.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        w1 = pend_word;
        for (int i = 0; i < 15; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("stall_fill15", {123'd0, obs_fill}, 128'd15);
        chk("stall_ready0", {127'd0, obs_rdy}, 128'd0);
        chk("stall_hold", obs_state, w1);
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("nobubble_valid", {127'd0, obs_valid}, 128'd1);
        chk("nobubble_lsb", {120'd0, obs_state[7:0]}, 128'hA5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush mid-word with a byte presented on the flush cycle.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b1);
        chk("flush_fill0", {123'd0, obs_fill}, 128'd0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h40 + 8'(i)), 1'b1, 1'b0);
        chk("flush_clean_word", obs_state, 128'h404142434445464748494A4B4C4D4E4F);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-word with a word pending.
        for (int i = 0; i < 25; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("pre_rst_fill9", {123'd0, obs_fill}, 128'd9);
        chk("pre_rst_valid", {127'd0, obs_valid}, 128'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", {127'd0, obs_valid}, 128'd0);
        chk("async_rst_state", obs_state, 128'd0);
        chk("async_rst_fill", {123'd0, obs_fill}, 128'd0);
        model_reset(0, 16);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
        chk("post_rst_msb", {120'd0, obs_state[127:120]}, 128'hC3);

        // Random stall stress for each width.
        for (int k = 0; k < 3; k++) begin
            rst = 1'b1;
            model_reset(k, (k == 0) ? 16 : ((k == 1) ? 4 : 1));
            @(negedge clk); rst = 1'b0;
            @(posedge clk); #1;
            words_out = 0;
            for (int i = 0; i < 700; i++) begin
                cycle(($urandom_range(3, 0) != 0), 8'($urandom),
                      ($urandom_range(2, 0) != 0), ($urandom_range(79, 0) == 0));
            end
            for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
            chk("stress_words_seen", 128'(words_out > 4), 128'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
